// File: rtl/piso_tx_if.sv
// ----------------------------------------------------------------------------
// piso_tx_if -- load/serial-out bundle for the piso_tx serialiser.
//
// Signals:
//   load     : request to accept pi as a new word        (master -> slave)
//   pi       : parallel word, WIDTH bits                  (master -> slave)
//   ready    : a load is accepted this cycle if asserted  (slave  -> master)
//   so       : serial data, one bit per clk               (slave  -> master)
//   so_valid : so carries a word bit                      (slave  -> master)
//   done     : pulse with the last bit of a word          (slave  -> master)
//
// Modports: master = word producer / serial consumer, slave = piso_tx.
// ----------------------------------------------------------------------------
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] pi;
    logic             ready;
    logic             so;
    logic             so_valid;
    logic             done;

    modport master (
        output load, pi,
        input  ready, so, so_valid, done
    );

    modport slave (
        input  load, pi,
        output ready, so, so_valid, done
    );
endinterface

// File: rtl/piso_tx.sv
// ----------------------------------------------------------------------------
// piso_tx -- parallel-in / serial-out transmitter.
//
// A word on bus.pi is captured when bus.load and bus.ready are both high at a
// rising clk edge. It is then shifted out on bus.so one bit per cycle,
// starting the cycle after the accepting edge. bus.done marks the last bit.
// A new word may be accepted on the last-bit cycle, so consecutive words
// stream with no gap.
//
// Parameters:
//   WIDTH     : parallel word width, 2..32
//   MSB_FIRST : 1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : piso_tx_if slave modport (load, pi, ready, so, so_valid, done)
// ----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    piso_tx_if.slave    bus
);

    localparam int             CW    = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);
    localparam int             FIRST = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr_shifted;
    logic             last;
    logic             accept;

    // Last bit of the current word: the only SHIFT cycle that can take a load.
    assign last   = (state == SHIFT) && (cnt == LAST);
    assign accept = bus.load && bus.ready;

    // Vacated position is always filled with 0.
    always_comb begin
        sr_shifted = '0;
        if (MSB_FIRST)
            sr_shifted = {sr[WIDTH-2:0], 1'b0};
        else
            sr_shifted = {1'b0, sr[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the reset branch is synchronous (checked only
    // inside the clocked block) and also wins over a simultaneous load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else if (accept) begin
            // Covers both a load from IDLE and the back-to-back case.
            state <= SHIFT;
            sr    <= bus.pi;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            sr <= sr_shifted;
            if (last) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Outputs are pure decodes of registered state; ready is deliberately
    // combinational so a last-bit cycle can accept the next word.
    assign bus.ready    = (state == IDLE) || last;
    assign bus.so       = (state == SHIFT) ? sr[FIRST] : 1'b0;
    assign bus.so_valid = (state == SHIFT);
    assign bus.done     = last;

endmodule

// File: tb/tb_piso_tx.sv
// ----------------------------------------------------------------------------
// tb_piso_tx -- scoreboard bench for piso_tx.
//
// Two instances: one MSB-first, one LSB-first (both WIDTH=4). Stimulus pushes
// the expected serial bits (and the word a companion SIPO should assemble)
// into per-instance queues; a negedge monitor per instance pops and compares
// whenever so_valid is high, and checks so/done are quiet otherwise.
// ----------------------------------------------------------------------------
module tb_piso_tx;

    logic clk;
    logic rst_n;

    piso_tx_if #(.WIDTH(4)) m_if ();
    piso_tx_if #(.WIDTH(4)) l_if ();

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (l_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic d;
    } exp_t;

    exp_t       m_q[$];
    exp_t       l_q[$];
    logic [3:0] m_w[$];
    logic [3:0] l_w[$];

    int tests  = 0;
    int failed = 0;
    bit mon_en = 1'b0;

    logic [3:0] m_sipo = '0;
    logic [3:0] l_sipo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue the first nbits of word w in shift order; done only on bit 4.
    task automatic push_word(input bit lsb, input logic [3:0] w, input int nbits);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            e.b = lsb ? w[i] : w[3-i];
            e.d = (i == 3);
            if (lsb) l_q.push_back(e);
            else     m_q.push_back(e);
        end
        if (nbits == 4) begin
            if (lsb) l_w.push_back(w);
            else     m_w.push_back(w);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // MSB-first monitor with a companion SIPO shifting left.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] w;
        if (mon_en) begin
            if (m_if.so_valid) begin
                m_sipo = {m_sipo[2:0], m_if.so};
                if (m_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL msb_extra_bit: got so=%0b with nothing expected (t=%0t)", m_if.so, $time);
                end else begin
                    e = m_q.pop_front();
                    check("msb_so", m_if.so, e.b);
                    check("msb_done", m_if.done, e.d);
                    if (e.d && m_w.size() != 0) begin
                        w = m_w.pop_front();
                        check("msb_sipo_q", m_sipo, w);
                    end
                end
            end else begin
                check("msb_idle_so", m_if.so, 1'b0);
                check("msb_idle_done", m_if.done, 1'b0);
            end
        end
    end

    // LSB-first monitor with a companion SIPO shifting right.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] w;
        if (mon_en) begin
            if (l_if.so_valid) begin
                l_sipo = {l_if.so, l_sipo[3:1]};
                if (l_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL lsb_extra_bit: got so=%0b with nothing expected (t=%0t)", l_if.so, $time);
                end else begin
                    e = l_q.pop_front();
                    check("lsb_so", l_if.so, e.b);
                    check("lsb_done", l_if.done, e.d);
                    if (e.d && l_w.size() != 0) begin
                        w = l_w.pop_front();
                        check("lsb_sipo_q", l_sipo, w);
                    end
                end
            end else begin
                check("lsb_idle_so", l_if.so, 1'b0);
                check("lsb_idle_done", l_if.done, 1'b0);
            end
        end
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        m_if.load = 1'b0;
        m_if.pi   = '0;
        l_if.load = 1'b0;
        l_if.pi   = '0;
        step();
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Reset state.
        check("rst_so",       m_if.so,       1'b0);
        check("rst_so_valid", m_if.so_valid, 1'b0);
        check("rst_done",     m_if.done,     1'b0);
        check("rst_ready",    m_if.ready,    1'b1);
        check("rst_ready_l",  l_if.ready,    1'b1);

        // Basic MSB-first word 1001; pi changes after acceptance are ignored.
        m_if.load = 1'b1;
        m_if.pi   = 4'b1001;
        push_word(1'b0, 4'b1001, 4);
        step();
        check("msb_first_bit_valid", m_if.so_valid, 1'b1);
        check("msb_busy_ready", m_if.ready, 1'b0);
        m_if.load = 1'b0;
        m_if.pi   = 4'b0110;
        repeat (6) step();

        // Load attempts during bits 1-3 of word 0110 must be ignored.
        m_if.load = 1'b1;
        m_if.pi   = 4'b0110;
        push_word(1'b0, 4'b0110, 4);
        step();
        m_if.pi = 4'b1111;
        repeat (3) step();
        m_if.load = 1'b0;
        repeat (5) step();

        // Back-to-back: 1010 then 0110 presented on the done cycle.
        m_if.load = 1'b1;
        m_if.pi   = 4'b1010;
        push_word(1'b0, 4'b1010, 4);
        for (int c = 1; c <= 8; c++) begin
            step();
            check("b2b_so_valid", m_if.so_valid, 1'b1);
            if (c == 4) begin
                check("b2b_ready_at_done", m_if.ready, 1'b1);
                m_if.pi = 4'b0110;
                push_word(1'b0, 4'b0110, 4);
            end
            if (c == 5) m_if.load = 1'b0;
        end
        step();
        check("b2b_idle_after", m_if.so_valid, 1'b0);
        repeat (3) step();

        // LSB-first word 0011 -> 1,1,0,0 then idle.
        l_if.load = 1'b1;
        l_if.pi   = 4'b0011;
        push_word(1'b1, 4'b0011, 4);
        step();
        l_if.load = 1'b0;
        repeat (4) step();
        check("lsb_idle_ready",    l_if.ready,    1'b1);
        check("lsb_idle_so_now",   l_if.so,       1'b0);
        check("lsb_idle_so_valid", l_if.so_valid, 1'b0);
        repeat (2) step();

        // Reset after bit 2 of 1101: only bits 1,1 are emitted, no done.
        m_if.load = 1'b1;
        m_if.pi   = 4'b1101;
        push_word(1'b0, 4'b1101, 2);
        step();
        m_if.load = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_so",       m_if.so,       1'b0);
        check("abort_so_valid", m_if.so_valid, 1'b0);
        check("abort_done",     m_if.done,     1'b0);
        check("abort_ready",    m_if.ready,    1'b1);
        m_if.load = 1'b1;
        m_if.pi   = 4'b0001;
        push_word(1'b0, 4'b0001, 4);
        step();
        m_if.load = 1'b0;
        repeat (6) step();

        // Reset and load on the same edge: the load is discarded.
        rst_n     = 1'b0;
        m_if.load = 1'b1;
        m_if.pi   = 4'b1111;
        step();
        rst_n     = 1'b1;
        m_if.load = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("rst_load_no_word", m_if.so_valid, 1'b0);
            step();
        end

        // Drain: every expected bit must have been seen.
        n = 0;
        while ((m_q.size() != 0 || l_q.size() != 0) && n < 50) begin
            step();
            n++;
        end
        check("msb_queue_drained", m_q.size(), 0);
        check("lsb_queue_drained", l_q.size(), 0);
        check("msb_words_drained", m_w.size(), 0);
        check("lsb_words_drained", l_w.size(), 0);

        @(negedge clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 out first, 0 shifts bit 0 out first.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, synchronous active-low reset sampled on the rising clk edge.
REQ-005 The block SHALL have port load, input, 1, request to accept pi as a new word.
REQ-006 The block SHALL have port pi, input, WIDTH, parallel word to serialise.
REQ-007 The block SHALL have port ready, output, 1, high when a load is accepted this cycle.
REQ-008 The block SHALL have port so, output, 1, serial data out, one bit per clk cycle, feeding the si input of the companion SIPO.
REQ-009 The block SHALL have port so_valid, output, 1, high while so carries a word bit.
REQ-010 The block SHALL have port done, output, 1, single-cycle pulse coincident with the last bit of a word.

Function
REQ-011 The block SHALL implement FSM states IDLE and SHIFT, plus a shift register of WIDTH bits and a bit counter of ceil(log2(WIDTH)) bits.
REQ-012 Load SHALL be accepted only on a rising edge where load=1 and ready=1; load while ready=0 SHALL be ignored, with no state change and no latching.
REQ-013 ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when counter = WIDTH-1 (last bit); 0 otherwise.
REQ-014 On acceptance, pi SHALL be captured into the shift register, the counter cleared, and state set to SHIFT; the first bit SHALL appear on so in the cycle immediately after the accepting edge (latency 1).
REQ-015 In SHIFT, so SHALL present the current first-out bit of the shift register; each edge SHALL shift one position (left if MSB_FIRST=1, right if 0), fill with 0, and increment the counter.
REQ-016 so_valid SHALL be 1 for exactly WIDTH consecutive cycles per accepted word and 0 in IDLE.
REQ-017 done SHALL be 1 only in the SHIFT cycle where counter = WIDTH-1.
REQ-018 At counter = WIDTH-1 with no accepted load, the next state SHALL be IDLE.
REQ-019 At counter = WIDTH-1 with an accepted load, the new word SHALL be captured and SHIFT continued with counter 0, giving gap-free back-to-back words (so_valid stays 1).
REQ-020 In IDLE, so SHALL be driven 0.
REQ-021 pi changes after acceptance SHALL NOT affect the word being shifted.

Reset
REQ-022 With rst_n=0 at a rising edge, state SHALL become IDLE, the shift register and counter 0, regardless of load.
REQ-023 After reset: so=0, so_valid=0, done=0, ready=1.
REQ-024 Reset asserted mid-word SHALL abort the word; no remaining bits are emitted, and no done pulse occurs.
REQ-025 load sampled on the same edge as rst_n=0 SHALL be discarded.

Verification
REQ-026 Basic MSB-first: WIDTH=4, MSB_FIRST=1, load pi=4'b1001 once -> so = 1,0,0,1 on cycles 1-4 after acceptance; so_valid high on cycles 1-4; done on cycle 4; a companion SIPO clocked on the same clk shows q=4'b1001 after the 4th bit.
REQ-027 LSB-first: MSB_FIRST=0, pi=4'b0011 -> so = 1,1,0,0; done on the 4th bit; then IDLE with so=0 and ready=1.
REQ-028 Back-to-back: load held high with pi=4'b1010, then pi=4'b0110 presented at the done cycle -> 8 gap-free bits 1,0,1,0,0,1,1,0; so_valid continuously high for 8 cycles; two done pulses.
REQ-029 Ignored load: during bits 1-3 of a word, pulse load with pi=4'b1111 -> the output word is unchanged; no extra bits are emitted.
REQ-030 Reset mid-word: rst_n=0 on the edge after bit 2 of 4'b1101 -> the next cycle shows so=0, so_valid=0, done=0, ready=1; a following load of 4'b0001 produces a clean word 0,0,0,1.
REQ-031 Reset with load: rst_n=0 and load=1 on the same edge -> no word is emitted afterwards until a new load.
